if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INST, 32'h0000_0013, instruction injected into IF/ID on bubble/flush (addi x0,x0,0).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_we  in  1  1 = IF/ID may advance; 0 = hazard stall, hold IF/ID and PC.
REQ-006 flush  in  1  redirect request from jump control; discard in-flight/held fetch.
REQ-007 m4_1_cnt  in  2  redirect select: 01 target_b, 10 target_jr, 00/11 treated as 01.
REQ-008 target_b  in  32  branch/jal target.
REQ-009 target_jr  in  32  jalr target.
REQ-010 imem_req  out  1  fetch request, held until imem_ack.
REQ-011 imem_addr  out  32  fetch address, equals pc, stable while imem_req=1 and no ack.
REQ-012 imem_ack  in  1  one-cycle acknowledge; imem_rdata valid in the same cycle.
REQ-013 imem_rdata  in  32  fetched instruction.
REQ-014 id_inst  out  32  IF/ID instruction.
REQ-015 id_pc  out  32  IF/ID PC.
REQ-016 id_pc4  out  32  IF/ID PC+4.
REQ-017 id_valid  out  1  IF/ID holds a real instruction.

Function
REQ-018 States: FETCH (request outstanding), HOLD (instruction buffered, waiting for if_we), DRAIN (outstanding request to be discarded after flush).
REQ-019 FETCH: imem_req=1, imem_addr=pc; ack&&if_we -> IF/ID <= {rdata, pc, pc+4, valid=1}, pc <= pc+4, stay FETCH with new address next cycle.
REQ-020 FETCH: ack&&!if_we -> buffer <= {rdata, pc}, pc <= pc+4, go HOLD, IF/ID unchanged.
REQ-021 FETCH: !ack&&if_we -> IF/ID <= {NOP_INST, id_pc, id_pc4, valid=0} (bubble); !ack&&!if_we -> IF/ID unchanged.
REQ-022 HOLD: imem_req=0; if_we -> IF/ID <= buffer with valid=1, go FETCH; !if_we -> hold all.
REQ-023 Flush (any state, priority over if_we and ack): IF/ID <= {NOP_INST, valid=0}; pc <= selected target; buffer invalidated.
REQ-024 Flush in FETCH with ack same cycle -> rdata discarded, next state FETCH at target.
REQ-025 Flush in FETCH without ack -> go DRAIN; imem_req stays 1 with old address until ack; ack discarded; then FETCH at target.
REQ-026 Flush in HOLD -> FETCH at target; flush in DRAIN -> pc updated to newest target, remain DRAIN.
REQ-027 DRAIN: IF/ID stays NOP/valid=0 regardless of if_we.
REQ-028 PC arithmetic modulo 2^32; pc+4 from 32'hFFFF_FFFC wraps to 0; targets used unaligned as given.
REQ-029 Fetch-to-IF/ID latency: IF/ID updates on the edge where imem_ack=1 and if_we=1; zero extra cycles.
REQ-030 imem_req shall never deassert between request and ack (no cancel).

Reset
REQ-031 rst=1 on an edge: pc<=RESET_PC, state<=FETCH, buffer invalid, id_inst<=NOP_INST, id_pc<=0, id_pc4<=0, id_valid<=0; overrides flush/ack.
REQ-032 imem_req=1, imem_addr=RESET_PC the first cycle after reset release.
REQ-033 Reset mid-transaction abandons the request; memory model shall ignore the pending ack.

Verification
REQ-034 Reset, ack every cycle, if_we=1 -> id_pc sequence 0,4,8,C with id_valid=1 each cycle.
REQ-035 Ack at pc=8 with if_we=0 for 3 cycles -> state HOLD, imem_req=0, IF/ID holds pc=4; if_we=1 -> id_pc=8, next fetch at C.
REQ-036 Ack delayed 2 cycles, if_we=1 -> two bubbles (NOP_INST, valid=0), then instruction delivered.
REQ-037 Flush with m4_1_cnt=10, target_jr=0x100 while request at 0x20 pending -> DRAIN, old ack discarded, next imem_addr=0x100, id_valid=0 until 0x100 delivered.
REQ-038 Flush and ack same cycle, m4_1_cnt=01, target_b=0x40 -> rdata dropped, imem_addr=0x40 next cycle.
REQ-039 pc=0xFFFF_FFFC, ack, if_we=1 -> id_pc4=0, next imem_addr=0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with a one-entry hold buffer and flush/redirect handling.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_we,
  input  logic        flush,
  input  logic [1:0]  m4_1_cnt,
  input  logic [31:0] target_b,
  input  logic [31:0] target_jr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid
);
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
  state_t      r_state;
  logic [31:0] r_pc, r_addr, r_buf_inst, r_buf_pc, r_id_inst, r_id_pc, r_id_pc4;
  logic        r_id_valid;
  logic [31:0] w_tgt, w_pc4;
  always_comb begin
    w_tgt = (m4_1_cnt == 2'b10) ? target_jr : target_b;
    w_pc4 = r_pc + 32'd4;
  end
  // r_addr keeps the abandoned address on the bus while a flushed request drains
  assign imem_req  = r_state != HOLD;
  assign imem_addr = (r_state == DRAIN) ? r_addr : r_pc;
  assign id_inst   = r_id_inst;
  assign id_pc     = r_id_pc;
  assign id_pc4    = r_id_pc4;
  assign id_valid  = r_id_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_buf_inst <= NOP_INST;
      r_buf_pc   <= '0;
      r_id_inst  <= NOP_INST;
      r_id_pc    <= '0;
      r_id_pc4   <= '0;
      r_id_valid <= 1'b0;
    end else if (flush) begin
      r_pc       <= w_tgt;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
      r_state    <= (r_state == HOLD || imem_ack) ? FETCH : DRAIN;
      if (r_state == FETCH) r_addr <= r_pc;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ack) begin
            r_pc <= w_pc4;
            if (if_we) begin
              r_id_inst  <= imem_rdata;
              r_id_pc    <= r_pc;
              r_id_pc4   <= w_pc4;
              r_id_valid <= 1'b1;
            end else begin
              r_buf_inst <= imem_rdata;
              r_buf_pc   <= r_pc;
              r_state    <= HOLD;
            end
          end else if (if_we) begin
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (if_we) begin
            r_id_inst  <= r_buf_inst;
            r_id_pc    <= r_buf_pc;
            r_id_pc4   <= r_buf_pc + 32'd4;
            r_id_valid <= 1'b1;
            r_state    <= FETCH;
          end
        end
        DRAIN: begin
          r_id_inst  <= NOP_INST;
          r_id_valid <= 1'b0;
          if (imem_ack) r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end
endmodule
